dmem_responder: RTL and testbench

//   Responder end of the processor's data-memory port: serves address_dmem/data/wren and returns q_dmem.

---
 rtl/dmem_responder_pkg.sv | 20 ++
 rtl/dmem_responder_tx_fifo.sv | 66 ++++++
 rtl/dmem_responder.sv | 125 ++++++++++++
 tb/tb_dmem_responder.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared MMIO offsets, STATUS bit positions and region type
package dmem_responder_pkg;

  // Word offsets inside the MMIO window, counted from MMIO_BASE
  localparam logic [1:0] MMIO_TX     = 2'd0;
  localparam logic [1:0] MMIO_STATUS = 2'd1;
  localparam logic [1:0] MMIO_DROPS  = 2'd2;
  localparam logic [1:0] MMIO_ERR    = 2'd3;

  // STATUS word layout: count in [7:0], full flag, empty flag
  localparam int STATUS_FULL_BIT  = 8;
  localparam int STATUS_EMPTY_BIT = 9;

  typedef enum logic [1:0] {
    REGION_RAM  = 2'd0,
    REGION_MMIO = 2'd1,
    REGION_OOB  = 2'd2
  } region_e;

endpackage

// File: rtl/dmem_responder_tx_fifo.sv
// rtl/dmem_responder_tx_fifo.sv - synchronous TX FIFO with push/pop, full/empty and count
module dmem_responder_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  // Head reads as zero when empty so the stream data bus is quiet after reset
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when the head leaves on the same edge
  always_comb begin
    do_pop   = pop_i & ~empty_o;
    do_push  = push_i & (~full_o | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards everything queued
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; a push coinciding with reset is not written
  always_ff @(posedge clock) begin
    if (!reset && do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: word RAM, console MMIO window, TX stream
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_F000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        oob_err
);

  localparam int         CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [1:0] MMIO_LO = MMIO_BASE[1:0];

  logic [31:0] ram_q [2**ADDR_WIDTH];

  logic [31:0] q_dmem_q, q_dmem_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;
  logic        oob_err_q, oob_err_d;

  region_e     region;
  logic [1:0]  mmio_off;
  logic        push, pop, drop;
  logic        fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0] status_word;

  assign q_dmem   = q_dmem_q;
  assign oob_err  = oob_err_q;
  assign tx_valid = ~fifo_empty;
  assign mmio_off = address_dmem[1:0] - MMIO_LO;

  dmem_responder_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_tx_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (data),
    .pop_i       (pop),
    .head_o      (tx_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Address decode, MMIO side effects and load-data selection (all from pre-edge state)
  always_comb begin
    region      = REGION_OOB;
    status_word = '0;
    q_dmem_d    = '0;
    push        = 1'b0;
    pop         = tx_valid & tx_ready;
    drop        = 1'b0;
    drop_cnt_d  = drop_cnt_q;
    oob_err_d   = oob_err_q;

    if ((address_dmem >> ADDR_WIDTH) == 32'd0) begin
      region = REGION_RAM;
    end else if (address_dmem >= MMIO_BASE && address_dmem <= MMIO_BASE + 32'd3) begin
      region = REGION_MMIO;
    end

    status_word[7:0]              = 8'(fifo_count);
    status_word[STATUS_FULL_BIT]  = fifo_full;
    status_word[STATUS_EMPTY_BIT] = fifo_empty;

    push = wren && (region == REGION_MMIO) && (mmio_off == MMIO_TX);
    drop = push & fifo_full & ~pop;

    if (drop && drop_cnt_q != 32'hFFFF_FFFF) begin
      drop_cnt_d = drop_cnt_q + 32'd1;
    end

    case (region)
      REGION_RAM: q_dmem_d = ram_q[address_dmem[ADDR_WIDTH-1:0]];
      REGION_MMIO: begin
        case (mmio_off)
          MMIO_STATUS: q_dmem_d = status_word;
          MMIO_DROPS:  q_dmem_d = drop_cnt_q;
          MMIO_ERR:    q_dmem_d = {31'b0, oob_err_q};
          default:     q_dmem_d = '0;
        endcase
        // Clearing stores win over a same-edge drop or error
        if (wren && mmio_off == MMIO_DROPS) drop_cnt_d = '0;
        if (wren && mmio_off == MMIO_ERR)   oob_err_d  = 1'b0;
      end
      default: begin
        q_dmem_d  = '0;
        oob_err_d = 1'b1;
      end
    endcase
  end

  // Load data, drop counter and sticky error flag
  always_ff @(posedge clock) begin
    if (reset) begin
      q_dmem_q   <= '0;
      drop_cnt_q <= '0;
      oob_err_q  <= 1'b0;
    end else begin
      q_dmem_q   <= q_dmem_d;
      drop_cnt_q <= drop_cnt_d;
      oob_err_q  <= oob_err_d;
    end
  end

  // RAM write port; contents survive reset but a store coinciding with reset is dropped
  always_ff @(posedge clock) begin
    if (!reset && wren && region == REGION_RAM) begin
      ram_q[address_dmem[ADDR_WIDTH-1:0]] <= data;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h0000_F000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        oob_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  dmem_responder #(
    .ADDR_WIDTH (12),
    .MMIO_BASE  (BASE),
    .FIFO_DEPTH (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .oob_err      (oob_err)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    address_dmem = a; data = d; wren = 1'b1;
    tick();
    wren = 1'b0;
  endtask

  task automatic ld(input logic [31:0] a);
    address_dmem = a; wren = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; address_dmem = '0; data = '0; wren = 1'b0; tx_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_q", q_dmem, 32'h0);
    chk("rst_valid", {31'b0, tx_valid}, 32'h0);
    chk("rst_txdata", tx_data, 32'h0);
    chk("rst_oob", {31'b0, oob_err}, 32'h0);

    // store then load
    st(32'd5, 32'hDEAD_BEEF);
    ld(32'd5);
    chk("ld5", q_dmem, 32'hDEAD_BEEF);

    // same-cycle store/load returns old data
    st(32'd7, 32'h0);
    st(32'd7, 32'h1);
    chk("rdw_old", q_dmem, 32'h0);
    ld(32'd7);
    chk("rdw_new", q_dmem, 32'h1);

    // overfill TX FIFO with consumer stalled
    for (int i = 0; i < 10; i++) st(BASE, 32'd100 + i);
    chk("fill_valid", {31'b0, tx_valid}, 32'h1);
    ld(BASE + 32'd1);
    chk("fill_status", q_dmem, 32'h0000_0108);
    ld(BASE + 32'd2);
    chk("fill_drops", q_dmem, 32'd2);
    ld(BASE);
    chk("tx_load_zero", q_dmem, 32'h0);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", {31'b0, tx_valid}, 32'h1);
      chk("drain_data", tx_data, 32'd100 + i);
      tick();
    end
    tx_ready = 1'b0;
    chk("drained_valid", {31'b0, tx_valid}, 32'h0);
    ld(BASE + 32'd1);
    chk("drained_status", q_dmem, 32'h0000_0200);
    st(BASE + 32'd2, 32'h0);
    ld(BASE + 32'd2);
    chk("drops_cleared", q_dmem, 32'h0);

    // push and pop on the same edge while full
    for (int i = 0; i < 8; i++) st(BASE, 32'd200 + i);
    chk("full_head", tx_data, 32'd200);
    tx_ready = 1'b1;
    st(BASE, 32'd300);
    tx_ready = 1'b0;
    ld(BASE + 32'd1);
    chk("pp_status", q_dmem, 32'h0000_0108);
    ld(BASE + 32'd2);
    chk("pp_drops", q_dmem, 32'h0);
    tx_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      chk("pp_data", tx_data, (i == 8) ? 32'd300 : 32'd200 + i);
      tick();
    end
    tx_ready = 1'b0;
    chk("pp_empty", {31'b0, tx_valid}, 32'h0);

    // out-of-bounds access and error clear
    ld(32'h0000_2000);
    chk("oob_q", q_dmem, 32'h0);
    chk("oob_flag", {31'b0, oob_err}, 32'h1);
    ld(BASE + 32'd3);
    chk("err_read", q_dmem, 32'h1);
    st(BASE + 32'd3, 32'h0);
    chk("err_clear", {31'b0, oob_err}, 32'h0);

    // wren=0 at TX never pushes
    ld(BASE);
    chk("noload_push", {31'b0, tx_valid}, 32'h0);

    // reset with entries queued and a coincident TX store
    for (int i = 0; i < 9; i++) st(BASE, 32'd400 + i);
    ld(BASE + 32'd2);
    chk("pre_rst_drops", q_dmem, 32'd1);
    reset = 1'b1; address_dmem = BASE; data = 32'h55; wren = 1'b1;
    tick();
    reset = 1'b0; wren = 1'b0;
    chk("rst_mid_valid", {31'b0, tx_valid}, 32'h0);
    ld(BASE + 32'd1);
    chk("rst_mid_status", q_dmem, 32'h0000_0200);
    ld(BASE + 32'd2);
    chk("rst_mid_drops", q_dmem, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
